// File: rtl/vedic_pkg.sv
// Shared definitions for the iterative vedic multiplier: FSM state
// encoding and the digit / partial-product widths of the 2x2 cell.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;
    localparam int PP_W    = 4;

endpackage

// File: rtl/vedic2bit.sv
// 2x2 unsigned vedic multiplier cell: crosswise products summed with two
// half adders. v is the full 4-bit product; c is the final half-adder carry,
// which always equals v[3].
module vedic2bit
    import vedic_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic [PP_W-1:0]    v,
    output logic               c
);

    logic cross0;
    logic cross1;
    logic mid_carry;
    logic high;

    assign cross0    = a[1] & b[0];
    assign cross1    = a[0] & b[1];
    assign mid_carry = cross0 & cross1;
    assign high      = a[1] & b[1];

    assign v[0] = a[0] & b[0];
    assign v[1] = cross0 ^ cross1;
    assign v[2] = high ^ mid_carry;
    assign c    = high & mid_carry;
    assign v[3] = c;

endmodule

// File: rtl/vedic_seq_mult.sv
// Iterative WIDTH x WIDTH unsigned multiplier. Operands are split into
// 2-bit digits; one digit pair per cycle goes through a single vedic2bit
// cell and the shifted 4-bit partial product is added to a 2*WIDTH
// accumulator. Valid/ready handshakes on both the operand and result side.
module vedic_seq_mult
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int D     = WIDTH / DIGIT_W;
    localparam int PW    = 2 * WIDTH;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(D - 1);

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [PW-1:0]     acc;
    logic [IDX_W-1:0]  i_idx;
    logic [IDX_W-1:0]  j_idx;

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [PP_W-1:0]    pp;
    logic               pp_carry_unused;
    logic [IDX_W:0]     pos;
    logic [IDX_W+1:0]   shamt;
    logic [PW-1:0]      term;
    logic [PW-1:0]      acc_next;

    vedic2bit u_cell (
        .a (a_dig),
        .b (b_dig),
        .v (pp),
        .c (pp_carry_unused)
    );

    // Select the current digit pair and line its partial product up at 2*(i+j).
    always_comb begin
        a_dig    = a_reg[DIGIT_W*int'(i_idx) +: DIGIT_W];
        b_dig    = b_reg[DIGIT_W*int'(j_idx) +: DIGIT_W];
        pos      = (IDX_W+1)'(i_idx) + (IDX_W+1)'(j_idx);
        shamt    = {pos, 1'b0};
        term     = PW'(pp) << shamt;
        acc_next = acc + term;
    end

    // Control FSM with registered handshake outputs; j is the inner index, i the outer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a_in;
                        b_reg    <= b_in;
                        acc      <= '0;
                        i_idx    <= '0;
                        j_idx    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (j_idx == LAST) begin
                        j_idx <= '0;
                        if (i_idx == LAST) begin
                            i_idx     <= '0;
                            product   <= acc_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            i_idx <= i_idx + 1'b1;
                        end
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
